clarvi_load_return: RTL
=======================

Name: clarvi_load_return

Overview:
- Return-path partner of the byte-serial data-memory access unit.
- The access unit issues eight 1-byte reads per load (parts 0..7); this block collects the in-order read responses from data memory.
- It replaces bytes beyond the access width with zero/sign extension and streams the resulting 64-bit load value, LSB byte first, to writeback through a valid/ready handshake.
- It provides credit-based back-pressure (load_stall) to the issuing side.

Parameters:
- FIFO_DEPTH, 4, output byte FIFO entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered reads.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort of the current load (interrupt/redirect)
- req_valid  input  1  byte read issued this cycle (driven from main_read_enable)
- req_part  input  3  byte index of the issued read
- req_width  input  2  mem_width_t: B/H/W/D
- req_unsigned  input  1  zero-extend when 1, sign-extend when 0
- main_read_valid  input  1  memory response valid, in issue order, >=1 cycle after its request
- main_read_data  input  8  memory response byte
- out_ready  input  1  writeback accepts a byte
- out_valid  output  1  FIFO head valid
- out_data  output  8  extended load byte
- out_part  output  3  byte index of out_data
- out_last  output  1  out_part==7
- load_stall  output  1  issuing side must not assert req_valid
- load_busy  output  1  state != IDLE
- protocol_error  output  1  sticky protocol violation flag

Behaviour:
- Reset (reset low, async): state IDLE; FIFO empty; issue/response/outstanding/drop counters 0; all outputs 0.
- States and transitions:
  - IDLE -> ACTIVE on req_valid && req_part==0. Latch req_width and req_unsigned on this transition.
  - ACTIVE -> DRAIN when the 8th response is pushed.
  - DRAIN -> IDLE on the handshake (out_valid && out_ready) of the part-7 byte.
  - A new part-0 request in the same cycle as DRAIN->IDLE is accepted and moves straight to ACTIVE.
- Issue counter:
  - Expects req_part == issue count (0..7).
  - A mismatch, a req_valid while load_stall is 1, or a req_valid in DRAIN is a protocol error. The request is ignored for counting.
- Outstanding count:
  - +1 on an accepted request, -1 on a response.
  - Both in the same cycle leaves it unchanged.
- Response k (rx counter, 0..7):
  - nbytes = 1/2/4/8 for B/H/W/D.
  - k < nbytes: push main_read_data.
  - k == nbytes-1: also register sign = main_read_data[7].
  - k >= nbytes: push 8'h00 if unsigned, else {8{sign}}. The incoming byte is discarded; memory still returns it.
  - Every push carries part=k, last=(k==7).
- FIFO:
  - Registered output; out_valid = !empty.
  - Push and pop in the same cycle are legal when full (pop frees the slot).
  - Head data is stable while out_valid && !out_ready.
- load_stall (combinational from registered counts) = (outstanding + fifo_count >= FIFO_DEPTH) || (outstanding == MAX_OUTSTANDING) || drop_count != 0 || state == DRAIN.
  - This guarantees no FIFO overflow.
- Flush (the cycle flush is high):
  - FIFO cleared, state IDLE, issue/rx counters 0, drop_count <= outstanding (minus 1 if a response arrives the same cycle), outstanding <= 0.
  - Any req_valid in the flush cycle is ignored.
  - While drop_count != 0, each response decrements it and is not pushed.
  - load_busy is 1 while drop_count != 0.
- Response with outstanding==0 and drop_count==0: protocol error, byte dropped.
- Counter widths: $clog2(FIFO_DEPTH+1) for the FIFO count; $clog2(MAX_OUTSTANDING+1) for outstanding and drop_count.
- Latency: a response received in cycle N is visible on out_data in cycle N+1 if the FIFO was empty.

Optional Feature:
- Macro: CLARVI_LOAD_PROTOCOL_CHECK_EN.
- Defined: protocol_error is set on any violation listed in Behaviour. It stays set until reset; flush does not clear it.
- Undefined: protocol_error is tied 0 and the check logic is not built. Illegal stimulus behaviour is then undefined, but the FIFO is still never overrun by legal traffic.

Test Plan:
- LB signed, responses 0x80 then seven 0x55, out_ready=1 -> out_data 80,FF,FF,FF,FF,FF,FF,FF with out_part 0..7; out_last only on part 7; load_busy falls the cycle after part 7 is accepted.
- LHU, responses 0x34,0x92, six 0xAA -> 34,92,00,00,00,00,00,00.
- LW signed, responses EF,BE,AD,DE,x,x,x,x -> EF,BE,AD,DE,FF,FF,FF,FF. LD 01..08 with out_ready held 0 -> load_stall rises once outstanding+fifo_count reaches 4; no byte lost; order 01..08 after out_ready returns to 1.
- Flush after 3 requests and 2 responses -> drop_count=1; the next response is not output; out_valid stays 0; a following LW returns correct bytes with part starting at 0.
- Response with nothing outstanding -> protocol_error=1 and held through flush when CLARVI_LOAD_PROTOCOL_CHECK_EN is defined; protocol_error=0 when undefined.
- reset driven low mid-LD (fifo_count=2) -> out_valid, load_busy, load_stall go 0 immediately without a clock edge; after release, a new LB completes normally.

Source files
------------

// File: rtl/clarvi_load_return_if.sv
// -----------------------------------------------------------------------------
// clarvi_load_return_if
//   Signal bundle between the load return path, the issuing access unit,
//   data memory and writeback.
//
//   slave  : the load return block itself
//   master : the surrounding environment (issuer, memory, writeback)
//
//   Issue side     : flush, req_valid, req_part, req_width, req_unsigned,
//                    load_stall (back-pressure), load_busy, protocol_error
//   Memory side    : main_read_valid, main_read_data
//   Writeback side : out_valid, out_data, out_part, out_last, out_ready
// -----------------------------------------------------------------------------
interface clarvi_load_return_if;
  logic       flush;
  logic       req_valid;
  logic [2:0] req_part;
  logic [1:0] req_width;
  logic       req_unsigned;
  logic       main_read_valid;
  logic [7:0] main_read_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] out_part;
  logic       out_last;
  logic       load_stall;
  logic       load_busy;
  logic       protocol_error;

  modport slave (
    input  flush, req_valid, req_part, req_width, req_unsigned,
    input  main_read_valid, main_read_data, out_ready,
    output out_valid, out_data, out_part, out_last,
    output load_stall, load_busy, protocol_error
  );

  modport master (
    output flush, req_valid, req_part, req_width, req_unsigned,
    output main_read_valid, main_read_data, out_ready,
    input  out_valid, out_data, out_part, out_last,
    input  load_stall, load_busy, protocol_error
  );
endinterface

// File: rtl/clarvi_load_return.sv
// -----------------------------------------------------------------------------
// clarvi_load_return
//   Collects the eight in-order byte responses of a byte-serial load, replaces
//   bytes beyond the access width with zero/sign extension, and streams the
//   64-bit result LSB byte first through a small output FIFO to writeback.
//   Credit-style back-pressure (load_stall) keeps the FIFO from overflowing.
//
//   Ports:
//     clock : system clock, rising edge
//     reset : asynchronous, active-low
//     bus   : clarvi_load_return_if.slave (request, memory response,
//             writeback stream, stall/busy/protocol_error status)
//
//   Optional build macro CLARVI_LOAD_PROTOCOL_CHECK_EN: when defined, a sticky
//   protocol_error flag is built; otherwise protocol_error is tied low.
// -----------------------------------------------------------------------------
module clarvi_load_return #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                 clock,
  input logic                 reset,
  clarvi_load_return_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_issue_cnt;
  logic [2:0]     r_rx_cnt;
  logic [OW-1:0]  r_outst, r_drop;
  logic [CW-1:0]  r_count;
  logic [PW-1:0]  r_wptr, r_rptr;
  logic [1:0]     r_width;
  logic           r_unsigned, r_sign;
  logic [7:0]     r_fifo_data [FIFO_DEPTH];
  logic [2:0]     r_fifo_part [FIFO_DEPTH];

  logic           w_out_valid, w_pop, w_last_pop, w_stall, w_handover;
  logic           w_req_ok, w_start, w_rsp_drop, w_rsp_take, w_push, w_push_last;
  logic [7:0]     w_push_data;
  logic [OW-1:0]  w_pending, w_flush_drop;

  function automatic logic [3:0] nbytes(input logic [1:0] w);
    case (w)
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] ext_byte(input logic [2:0] k, input logic [1:0] w,
                                          input logic uns, input logic sign,
                                          input logic [7:0] d);
    if ({1'b0, k} < nbytes(w)) return d;
    return uns ? 8'h00 : {8{sign}};
  endfunction

  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_last_pop  = w_pop && (r_fifo_part[r_rptr] == 3'd7);

  assign w_stall = ((32'(r_outst) + 32'(r_count)) >= 32'(FIFO_DEPTH)) ||
                   (r_outst == OW'(MAX_OUTSTANDING)) ||
                   (r_drop != '0) || (r_state == S_DRAIN);

  // The next load's part 0 may ride on the cycle the previous load's last byte
  // leaves, even though the stall output is still high in DRAIN.
  assign w_handover = (r_state == S_DRAIN) && w_last_pop &&
                      bus.req_valid && (bus.req_part == 3'd0);
  assign w_req_ok   = !bus.flush && bus.req_valid &&
                      (w_handover || ((r_state != S_DRAIN) && !w_stall &&
                                      ({1'b0, bus.req_part} == r_issue_cnt)));
  assign w_start    = w_req_ok && (r_state != S_ACTIVE);

  assign w_rsp_drop  = bus.main_read_valid && (r_drop != '0);
  assign w_rsp_take  = bus.main_read_valid && (r_drop == '0) && (r_outst != '0);
  assign w_push      = w_rsp_take && !bus.flush;
  assign w_push_last = w_push && (r_rx_cnt == 3'd7);
  assign w_push_data = ext_byte(r_rx_cnt, r_width, r_unsigned, r_sign, bus.main_read_data);

  // Reads still in flight at flush time are owed back by memory and must be
  // swallowed; one arriving in the flush cycle itself is already accounted for.
  assign w_pending    = r_drop + r_outst;
  assign w_flush_drop = (bus.main_read_valid && (w_pending != '0)) ?
                        (w_pending - OW'(1)) : w_pending;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_start) w_state_nxt = S_ACTIVE;
        S_ACTIVE: if (w_push_last) w_state_nxt = S_DRAIN;
        S_DRAIN: begin
          if (w_handover)      w_state_nxt = S_ACTIVE;
          else if (w_last_pop) w_state_nxt = S_IDLE;
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_issue_cnt <= '0;
      r_rx_cnt    <= '0;
      r_outst     <= '0;
      r_drop      <= '0;
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else if (bus.flush) begin
      r_issue_cnt <= '0;
      r_rx_cnt    <= '0;
      r_outst     <= '0;
      r_drop      <= w_flush_drop;
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else begin
      if (w_start)                                r_issue_cnt <= 4'd1;
      else if (w_req_ok)                          r_issue_cnt <= r_issue_cnt + 4'd1;
      else if ((r_state == S_DRAIN) && w_last_pop) r_issue_cnt <= '0;

      // Wraps back to 0 after part 7, ready for the next load.
      if (w_push)     r_rx_cnt <= r_rx_cnt + 3'd1;
      if (w_rsp_drop) r_drop   <= r_drop - OW'(1);

      case ({w_req_ok, w_rsp_take})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: ;
      endcase

      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_start) begin
      r_width    <= bus.req_width;
      r_unsigned <= bus.req_unsigned;
    end
    if (w_push && ({1'b0, r_rx_cnt} == (nbytes(r_width) - 4'd1)))
      r_sign <= bus.main_read_data[7];
    if (w_push) begin
      r_fifo_data[r_wptr] <= w_push_data;
      r_fifo_part[r_wptr] <= r_rx_cnt;
    end
  end

  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? r_fifo_data[r_rptr] : 8'h00;
  assign bus.out_part   = w_out_valid ? r_fifo_part[r_rptr] : 3'd0;
  assign bus.out_last   = w_out_valid && (r_fifo_part[r_rptr] == 3'd7);
  assign bus.load_stall = w_stall;
  assign bus.load_busy  = (r_state != S_IDLE) || (r_drop != '0);

`ifdef CLARVI_LOAD_PROTOCOL_CHECK_EN
  logic r_proto_err;
  logic w_viol;

  // Any request that is not accepted outside a flush cycle is a violation
  // (wrong part, issued under stall, or issued in DRAIN), as is a response
  // that nothing was waiting for.
  assign w_viol = (bus.req_valid && !bus.flush && !w_req_ok) ||
                  (bus.main_read_valid && (r_drop == '0) && (r_outst == '0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_proto_err <= 1'b0;
    else if (w_viol) r_proto_err <= 1'b1;
  end

  assign bus.protocol_error = r_proto_err;
`else
  assign bus.protocol_error = 1'b0;
`endif

endmodule
